// File: rtl/iic_pll_pkg.sv
// Shared definitions for the IIC PLL reset generator: sequencer state encoding,
// timing defaults, lock-loss counter width and the shared-counter sizing helper.
package iic_pll_pkg;

    localparam int LOCK_STABLE_CYC_DEF  = 256;
    localparam int RST_HOLD_CYC_DEF     = 64;
    localparam int LOCK_TIMEOUT_CYC_DEF = 4096;
    localparam int PLL_RST_CYC_DEF      = 16;
    localparam int UNLOCK_CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4,
        ST_PLL_RST   = 3'd5
    } pll_state_t;

    // Counter only ever holds (parameter - 1), so clog2 of the largest one suffices.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/iic_sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into the i_clk domain.
module iic_sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/iic_pll_rst_gen.sv
// PLL lock qualifier and reset sequencer for the IIC clkout0 domain, with
// PLL re-reset on lock timeout and sticky lock-loss statistics.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   WAIT_LOCK  | waiting for lock_s; counts up toward the lock timeout
//   STABLE     | lock_s must stay high for LOCK_STABLE_CYC cycles
//   HOLD       | lock qualified; rst_out held for RST_HOLD_CYC more cycles
//   RUN        | rst_out released, ready asserted
//   LOST       | one-cycle lock-loss marker, back to WAIT_LOCK
//   PLL_RST    | pll_rst pulse of PLL_RST_CYC cycles after a timeout
module iic_pll_rst_gen
    import iic_pll_pkg::*;
#(
    parameter int LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int RST_HOLD_CYC     = RST_HOLD_CYC_DEF,
    parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int PLL_RST_CYC      = PLL_RST_CYC_DEF
) (
    input  logic                    clkin1,
    input  logic                    rst,
    input  logic                    lock,
    input  logic                    clr_stat,
    output logic                    pll_rst,
    output logic                    rst_out,
    output logic                    ready,
    output logic                    lock_lost,
    output logic [UNLOCK_CNT_W-1:0] unlock_cnt
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYC, RST_HOLD_CYC, LOCK_TIMEOUT_CYC, PLL_RST_CYC);

    localparam logic [CNT_W-1:0]        STABLE_LD  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]        HOLD_LD    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]        TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]        PLLRST_LD  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [UNLOCK_CNT_W-1:0] UNLOCK_MAX = '1;
    localparam logic [UNLOCK_CNT_W-1:0] UNLOCK_ONE = UNLOCK_CNT_W'(1);

    logic                    w_lock_s;
    logic                    w_loss;
    pll_state_t              r_state;
    pll_state_t              w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_pll_rst;
    logic                    r_rst_out;
    logic                    r_ready;
    logic                    r_lock_lost;
    logic [UNLOCK_CNT_W-1:0] r_unlock_cnt;

    iic_sync_2ff u_lock_sync (
        .i_clk (clkin1),
        .i_rst (rst),
        .i_d   (lock),
        .o_q   (w_lock_s)
    );

    // WAIT_LOCK counts elapsed cycles up from zero so a reset leaves the
    // timeout cleared; every other timed state counts down to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = STABLE_LD;
                end else if (r_cnt == TIMEOUT_TC) begin
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = PLLRST_LD;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_LOST;
                    w_loss      = 1'b1;
                end
            end
            ST_LOST: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
            ST_PLL_RST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pll_rst <= (w_state_nxt == ST_PLL_RST);
            r_rst_out <= (w_state_nxt != ST_RUN);
            r_ready   <= (w_state_nxt == ST_RUN);
        end
    end

    // A loss event wins over a coincident clear, leaving exactly one event counted.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            r_lock_lost  <= 1'b0;
            r_unlock_cnt <= '0;
        end else if (w_loss) begin
            r_lock_lost  <= 1'b1;
            if (clr_stat) begin
                r_unlock_cnt <= UNLOCK_ONE;
            end else if (r_unlock_cnt != UNLOCK_MAX) begin
                r_unlock_cnt <= r_unlock_cnt + 1'b1;
            end
        end else if (clr_stat) begin
            r_lock_lost  <= 1'b0;
            r_unlock_cnt <= '0;
        end
    end

    assign pll_rst    = r_pll_rst;
    assign rst_out    = r_rst_out;
    assign ready      = r_ready;
    assign lock_lost  = r_lock_lost;
    assign unlock_cnt = r_unlock_cnt;

endmodule

// File: tb/tb_iic_pll_rst_gen.sv
// Bench for iic_pll_rst_gen: one default-parameter and one short-timing instance
// checked every cycle against a run-length reference model plus directed checks.
module tb_iic_pll_rst_gen;

    localparam int D_LS = 256, D_RH = 64, D_TO = 4096, D_PR = 16;
    localparam int F_LS = 8,   F_RH = 4,  F_TO = 64,   F_PR = 4;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       clr_stat;
    logic       pll_rst_d, rst_out_d, ready_d, lost_d;
    logic [7:0] cnt_d;
    logic       pll_rst_f, rst_out_f, ready_f, lost_f;
    logic [7:0] cnt_f;

    int n_chk = 0;
    int n_err = 0;

    iic_pll_rst_gen u_dut (
        .clkin1     (clk),
        .rst        (rst),
        .lock       (lock),
        .clr_stat   (clr_stat),
        .pll_rst    (pll_rst_d),
        .rst_out    (rst_out_d),
        .ready      (ready_d),
        .lock_lost  (lost_d),
        .unlock_cnt (cnt_d)
    );

    iic_pll_rst_gen #(
        .LOCK_STABLE_CYC  (F_LS),
        .RST_HOLD_CYC     (F_RH),
        .LOCK_TIMEOUT_CYC (F_TO),
        .PLL_RST_CYC      (F_PR)
    ) u_dut_fast (
        .clkin1     (clk),
        .rst        (rst),
        .lock       (lock),
        .clr_stat   (clr_stat),
        .pll_rst    (pll_rst_f),
        .rst_out    (rst_out_f),
        .ready      (ready_f),
        .lock_lost  (lost_f),
        .unlock_cnt (cnt_f)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: hi = consecutive edges that saw lock_s high since the
    // sequence began, lo = consecutive waiting edges, pr = pulse edges left,
    // skip = the one edge spent marking a loss.
    typedef struct packed {
        int hi;
        int lo;
        int pr;
        bit skip;
        bit lost;
        int cnt;
        bit l1;
        bit l2;
    } mdl_t;

    mdl_t m_def = '0;
    mdl_t m_fast = '0;

    function automatic void mdl_step(inout mdl_t m, input bit r, input bit lk, input bit clr,
                                     input int ls, input int rh, input int to, input int prc);
        bit s;
        bit loss;
        s    = m.l2;
        loss = 1'b0;
        m.l2 = m.l1;
        m.l1 = lk;
        if (r) begin
            m = '0;
            return;
        end
        if (m.pr > 0) begin
            m.pr--;
        end else if (m.skip) begin
            m.skip = 1'b0;
        end else if (s) begin
            m.lo = 0;
            m.hi++;
        end else if (m.hi >= ls + rh + 1) begin
            loss   = 1'b1;
            m.hi   = 0;
            m.skip = 1'b1;
        end else if (m.hi > 0) begin
            m.hi = 0;
        end else begin
            m.lo++;
            if (m.lo == to) begin
                m.lo = 0;
                m.pr = prc;
            end
        end
        if (loss) begin
            m.lost = 1'b1;
            m.cnt  = clr ? 1 : ((m.cnt < 255) ? m.cnt + 1 : 255);
        end else if (clr) begin
            m.lost = 1'b0;
            m.cnt  = 0;
        end
    endfunction

    function automatic logic [11:0] mdl_out(input mdl_t m, input int need);
        logic rdy;
        rdy = (m.hi >= need);
        return {(m.pr > 0), !rdy, rdy, m.lost, m.cnt[7:0]};
    endfunction

    always @(posedge clk) begin
        mdl_step(m_def,  rst, lock, clr_stat, D_LS, D_RH, D_TO, D_PR);
        mdl_step(m_fast, rst, lock, clr_stat, F_LS, F_RH, F_TO, F_PR);
    end

    always @(negedge clk) begin
        check_eq("dflt_outs", {20'd0, pll_rst_d, rst_out_d, ready_d, lost_d, cnt_d},
                 {20'd0, mdl_out(m_def, D_LS + D_RH + 1)});
        check_eq("fast_outs", {20'd0, pll_rst_f, rst_out_f, ready_f, lost_f, cnt_f},
                 {20'd0, mdl_out(m_fast, F_LS + F_RH + 1)});
    end

    function automatic bit sig(input int which);
        case (which)
            0:       return ready_d;
            1:       return rst_out_d;
            2:       return pll_rst_d;
            3:       return !pll_rst_d;
            4:       return ready_f;
            default: return 1'b1;
        endcase
    endfunction

    task automatic count_until(input int which, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < bound);
    endtask

    initial begin
        int n;
        int n_hi;
        int len;
        rst      = 1'b1;
        lock     = 1'b0;
        clr_stat = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pll_rst", pll_rst_d, 0);
        check_eq("rst_rst_out", rst_out_d, 1);
        check_eq("rst_ready",   ready_d,   0);
        check_eq("rst_lost",    lost_d,    0);
        check_eq("rst_cnt",     cnt_d,     0);
        rst = 1'b0;

        // First lock after reset.
        repeat (47) @(negedge clk);
        lock = 1'b1;
        count_until(0, 1000, n);
        check_eq("lock_to_ready", n, 323);
        check_eq("run_rst_out", rst_out_d, 0);
        check_eq("run_cnt", cnt_d, 0);

        // Lock drop in RUN for 10 cycles, then re-lock.
        lock = 1'b0;
        count_until(1, 20, n);
        check_eq("drop_to_rst_out", n, 3);
        check_eq("drop_lost", lost_d, 1);
        check_eq("drop_cnt", cnt_d, 1);
        repeat (10 - n) @(negedge clk);
        lock = 1'b1;
        count_until(0, 1000, n);
        check_eq("relock_to_ready", n, 323);

        // Lock drop inside STABLE: not a loss event, full count restarts.
        lock = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("second_loss_cnt", cnt_d, 2);
        lock = 1'b1;
        repeat (202) @(negedge clk);
        lock = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("stable_drop_ready", ready_d, 0);
        check_eq("stable_drop_cnt", cnt_d, 2);
        lock = 1'b1;
        count_until(0, 1000, n);
        check_eq("restart_to_ready", n, 323);

        // No lock: PLL reset pulses.
        lock = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_until(2, 5000, n);
        check_eq("timeout_start", n, 4096);
        check_eq("timeout_rst_out", rst_out_d, 1);
        count_until(3, 100, n_hi);
        check_eq("pll_rst_width", n_hi, 16);
        count_until(2, 5000, n);
        check_eq("pll_rst_period", n_hi + n, 4112);
        check_eq("period_rst_out", rst_out_d, 1);

        // Reset during PLL_RST cycle 5.
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_pll_rst", pll_rst_d, 0);
        check_eq("midrst_rst_out", rst_out_d, 1);
        check_eq("midrst_ready",   ready_d,   0);
        check_eq("midrst_lost",    lost_d,    0);
        check_eq("midrst_cnt",     cnt_d,     0);
        rst = 1'b0;

        // 300 loss events on the short-timing instance: counter saturates.
        for (int i = 0; i < 300; i++) begin
            lock = 1'b1;
            count_until(4, 100, n);
            if (i == 0) check_eq("fast_lock_to_ready", n, F_LS + F_RH + 3);
            lock = 1'b0;
            repeat (4) @(negedge clk);
        end
        check_eq("sat_cnt", cnt_f, 255);
        check_eq("sat_lost", lost_f, 1);
        lock = 1'b1;
        count_until(4, 100, n);
        lock = 1'b0;
        repeat (2) @(negedge clk);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        check_eq("clr_coinc_cnt", cnt_f, 1);
        check_eq("clr_coinc_lost", lost_f, 1);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        check_eq("clr_cnt", cnt_f, 0);
        check_eq("clr_lost", lost_f, 0);

        // Random lock waveform with sparse clears and resets.
        for (int i = 0; i < 150; i++) begin
            lock = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 40);
            repeat (len) begin
                @(negedge clk);
                clr_stat = ($urandom_range(0, 49) == 0);
                rst      = ($urandom_range(0, 999) == 0);
            end
        end
        rst      = 1'b0;
        clr_stat = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
